// File: rtl/vec_seq_engine.sv
// Vector register engine: NREGS registers of LANES x EW bits, with burst LOAD/STORE against a
// single-port word memory and lane-wise ADD/SUB/MUL. Commands are sequenced by an internal FSM.
module vec_seq_engine #(
  parameter int unsigned LANES = 16,
  parameter int unsigned EW    = 32,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 9,
  parameter int unsigned RW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [RW-1:0]       cmd_rd,
  input  logic [RW-1:0]       cmd_rs1,
  input  logic [RW-1:0]       cmd_rs2,
  input  logic [AW-1:0]       cmd_addr,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [EW-1:0]       mem_wdata,
  input  logic [EW-1:0]       mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [RW-1:0]       dbg_sel,
  output logic [LANES*EW-1:0] dbg_data
);

  localparam int unsigned KW = $clog2(LANES);
  localparam int unsigned VW = LANES * EW;

  typedef enum logic [2:0] {StIdle, StLoad, StLtail, StStore, StExec, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [RW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [AW-1:0]   base_q, base_d;
  logic [KW-1:0]   k_q, k_d, k_prev;
  logic            err_q, err_d;
  logic [VW-1:0]   regs_q [NREGS];
  logic [VW-1:0]   regs_d [NREGS];
  logic [VW-1:0]   exec_res;
  logic [EW-1:0]   op_a, op_b;
  logic            last_lane;

  assign last_lane = (k_q == KW'(LANES - 1));
  assign k_prev    = k_q - 1'b1;

  // All lanes computed from the pre-update register values, so rd may alias a source.
  always_comb begin
    exec_res = '0;
    op_a     = '0;
    op_b     = '0;
    for (int i = 0; i < LANES; i++) begin
      op_a = regs_q[rs1_q][i*EW +: EW];
      op_b = regs_q[rs2_q][i*EW +: EW];
      unique case (op_q)
        3'd2:    exec_res[i*EW +: EW] = op_a + op_b;
        3'd3:    exec_res[i*EW +: EW] = op_a - op_b;
        default: exec_res[i*EW +: EW] = op_a * op_b;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    base_d    = base_q;
    k_d       = k_q;
    err_d     = err_q;
    regs_d    = regs_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          rd_d   = cmd_rd;
          rs1_d  = cmd_rs1;
          rs2_d  = cmd_rs2;
          base_d = cmd_addr;
          k_d    = '0;
          err_d  = 1'b0;
          unique case (cmd_op)
            3'd0:                 state_d = StLoad;
            3'd1:                 state_d = StStore;
            3'd2, 3'd3, 3'd4:     state_d = StExec;
            default: begin
              state_d = StDone;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StLoad: begin
        mem_re   = 1'b1;
        mem_addr = base_q + AW'(k_q);
        // Read data lags the strobe by one cycle, so this cycle lands the previous lane.
        if (k_q != '0) regs_d[rd_q][k_prev*EW +: EW] = mem_rdata;
        k_d = k_q + 1'b1;
        if (last_lane) state_d = StLtail;
      end
      StLtail: begin
        regs_d[rd_q][(LANES-1)*EW +: EW] = mem_rdata;
        state_d = StDone;
      end
      StStore: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + AW'(k_q);
        mem_wdata = regs_q[rs1_q][k_q*EW +: EW];
        k_d       = k_q + 1'b1;
        if (last_lane) state_d = StDone;
      end
      StExec: begin
        regs_d[rd_q] = exec_res;
        state_d      = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = done && err_q;
  assign dbg_data  = regs_q[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      base_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      base_q  <= base_d;
      k_q     <= k_d;
      err_q   <= err_d;
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
    end
  end

endmodule

// File: tb/tb_vec_seq_engine.sv
// Bench for vec_seq_engine: behavioural register/memory model, per-command trace checks and a
// per-cycle register comparison whenever the engine is idle or held in reset.
module tb_vec_seq_engine;

  localparam int LANES = 16;
  localparam int EW    = 32;
  localparam int NREGS = 4;
  localparam int AW    = 9;
  localparam int RW    = 2;
  localparam int VW    = LANES * EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [RW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [EW-1:0] mem_wdata;
  logic [EW-1:0] mem_rdata;
  logic          busy, done, err;
  logic [RW-1:0] dbg_sel;
  logic [VW-1:0] dbg_data;

  logic [EW-1:0] mem [1 << AW];
  logic [VW-1:0] model [NREGS];

  int n_checks = 0;
  int n_fail   = 0;

  vec_seq_engine #(
    .LANES(LANES), .EW(EW), .NREGS(NREGS), .AW(AW), .RW(RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_addr  (cmd_addr),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single-port memory: read data appears the cycle after the strobe.
  initial begin
    for (int j = 0; j < (1 << AW); j++) mem[j] = 32'(j + 1);
    for (int j = 'h080; j < 'h090; j++) mem[j] = 32'hFFFF_FFFF;
    for (int j = 'h090; j < 'h0A0; j++) mem[j] = 32'h2;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Registers observed through dbg port every idle (or reset) cycle, cycling dbg_sel.
  initial begin
    dbg_sel = '0;
    forever begin
      @(negedge clk);
      chk("strobe_excl", VW'(mem_re & mem_we), '0);
      if (!rst_n || cmd_ready) chk($sformatf("dbg_reg%0d", dbg_sel), dbg_data, model[dbg_sel]);
      dbg_sel = dbg_sel + 1'b1;
    end
  end

  task automatic run_cmd(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                         input logic [AW-1:0] addr);
    int done_at = 0, nre = 0, nwe = 0, exp_done, exp_re, exp_we;
    logic err_seen = 1'b0, trace_ok = 1'b1, busy_ok = 1'b1;
    logic [EW-1:0] a, b;
    logic [VW-1:0] t;
    chk("ready_before_cmd", VW'(cmd_ready), VW'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = RW'(rd);
    cmd_rs1   = RW'(rs1);
    cmd_rs2   = RW'(rs2);
    cmd_addr  = addr;
    @(posedge clk); #1;
    // Keep valid high with different fields: must be ignored while busy.
    cmd_op   = 3'd2;
    cmd_rd   = ~cmd_rd;
    cmd_rs1  = ~cmd_rs1;
    cmd_addr = addr ^ 9'h155;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      if (mem_re) begin
        if (nre != n - 1 || mem_addr !== AW'(addr + nre)) trace_ok = 1'b0;
        nre++;
      end
      if (mem_we) begin
        if (nwe != n - 1 || nwe >= LANES || mem_addr !== AW'(addr + nwe)) trace_ok = 1'b0;
        else if (mem_wdata !== model[rs1][nwe*EW +: EW]) trace_ok = 1'b0;
        nwe++;
      end
      if (done) begin
        done_at  = n;
        err_seen = err;
      end else begin
        if (!busy || cmd_ready) busy_ok = 1'b0;
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
    case (op)
      3'd0:             begin exp_done = LANES + 2; exp_re = LANES; exp_we = 0;     end
      3'd1:             begin exp_done = LANES + 1; exp_re = 0;     exp_we = LANES; end
      3'd2, 3'd3, 3'd4: begin exp_done = 2;         exp_re = 0;     exp_we = 0;     end
      default:          begin exp_done = 1;         exp_re = 0;     exp_we = 0;     end
    endcase
    chk($sformatf("done_cycle_op%0d", op), VW'(done_at), VW'(exp_done));
    chk($sformatf("err_op%0d", op), VW'(err_seen), VW'(op > 3'd4));
    chk($sformatf("reads_op%0d", op), VW'(nre), VW'(exp_re));
    chk($sformatf("writes_op%0d", op), VW'(nwe), VW'(exp_we));
    chk($sformatf("trace_op%0d", op), VW'(trace_ok), VW'(1));
    chk($sformatf("busy_op%0d", op), VW'(busy_ok), VW'(1));
    t = model[rd];
    for (int i = 0; i < LANES; i++) begin
      a = model[rs1][i*EW +: EW];
      b = model[rs2][i*EW +: EW];
      case (op)
        3'd0: t[i*EW +: EW] = mem[AW'(addr + i)];
        3'd2: t[i*EW +: EW] = a + b;
        3'd3: t[i*EW +: EW] = a - b;
        3'd4: t[i*EW +: EW] = EW'(64'(a) * 64'(b));
        default: ;
      endcase
    end
    if (op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd4) model[rd] = t;
    @(posedge clk); #1;
    chk("done_one_cycle", VW'({done, cmd_ready}), VW'(2'b01));
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) model[r] = '0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_addr = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ready_busy", VW'({cmd_ready, busy}), VW'(2'b10));
    chk("rst_done_err", VW'({done, err}), '0);
    chk("rst_strobes", VW'({mem_re, mem_we}), '0);
    chk("rst_addr_wdata", VW'({mem_addr, mem_wdata}), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(3'd0, 1, 0, 0, 9'h010);
    chk("lit_load_l0", VW'(model[1][31:0]), VW'(32'h11));
    chk("lit_load_l15", VW'(model[1][15*EW +: EW]), VW'(32'h20));
    run_cmd(3'd0, 2, 0, 0, 9'h1FA);
    chk("lit_wrap_l5", VW'(model[2][5*EW +: EW]), VW'(32'h200));
    chk("lit_wrap_l6", VW'(model[2][6*EW +: EW]), VW'(32'h1));
    run_cmd(3'd0, 1, 0, 0, 9'h080);
    run_cmd(3'd0, 2, 0, 0, 9'h090);
    run_cmd(3'd2, 3, 1, 2, 9'h000);
    chk("lit_add", VW'(model[3][9*EW +: EW]), VW'(32'h1));
    run_cmd(3'd3, 3, 2, 1, 9'h000);
    chk("lit_sub", VW'(model[3][0 +: EW]), VW'(32'h3));
    run_cmd(3'd4, 1, 1, 2, 9'h000);
    chk("lit_mul", VW'(model[1][15*EW +: EW]), VW'(32'hFFFF_FFFE));
    run_cmd(3'd1, 0, 3, 0, 9'h100);
    run_cmd(3'd6, 0, 1, 2, 9'h0AA);
    run_cmd(3'd0, 0, 0, 0, 9'h100);
    chk("lit_store_back", VW'(model[0][7*EW +: EW]), VW'(32'h3));

    // Reset asserted while LOAD is issuing lane 5.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 2'd2; cmd_addr = 9'h000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_lane5_addr", VW'({mem_re, mem_addr}), VW'({1'b1, 9'h005}));
    rst_n = 1'b0;
    for (int r = 0; r < NREGS; r++) model[r] = '0;
    #1;
    chk("midrst_strobe_drop", VW'({mem_re, mem_we, busy, done}), '0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", VW'({done, cmd_ready}), VW'(2'b01));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(3'd0, 2, 0, 0, 9'h010);
    chk("lit_after_rst", VW'(model[2][3*EW +: EW]), VW'(32'h14));
    repeat (6) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_seq_engine.md
# vec_seq_engine

Parametrised vector engine that succeeds the fixed 4×512-bit register-file/math/memory top. It holds NREGS vector registers of LANES×EW bits and executes one command at a time: burst LOAD from, or STORE to, an external word memory, and lane-wise ADD/SUB/MUL between registers. A sequencing FSM replaces the external per-cycle control of the previous generation, so the block sits between a command issuer and a single-port word memory.

## Interface
Parameters:
- LANES, 16, elements per vector (≥2)
- EW, 32, element width in bits
- NREGS, 4, number of vector registers (power of 2, ≥2)
- AW, 9, memory word-address width
- RW, $clog2(NREGS), register-index width (derived)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command (high only in IDLE)
- cmd_op  in  3  0=LOAD, 1=STORE, 2=ADD, 3=SUB, 4=MUL, 5–7 illegal
- cmd_rd  in  RW  destination register (LOAD/ADD/SUB/MUL)
- cmd_rs1  in  RW  source 1 (STORE data source; first arithmetic operand)
- cmd_rs2  in  RW  source 2 (arithmetic only)
- cmd_addr  in  AW  base word address (LOAD/STORE)
- mem_addr  out  AW  memory word address
- mem_re  out  1  memory read strobe; mem_rdata valid exactly one cycle later
- mem_we  out  1  memory write strobe
- mem_wdata  out  EW  write data
- mem_rdata  in  EW  read data
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at command completion
- err  out  1  with done: command was illegal
- dbg_sel  in  RW  register selected for observation
- dbg_data  out  LANES*EW  combinational view of register dbg_sel

## Operation
- Lane i occupies bits [i*EW +: EW]; lane 0 maps to cmd_addr, lane i to (cmd_addr+i) mod 2^AW (address wraps, no error).
- Command latched (op, indices, addr) on the edge where cmd_valid && cmd_ready; later changes of cmd_* ignored until next accept.
- FSM states: IDLE, LOAD, LTAIL, STORE, EXEC, DONE.
- IDLE: cmd_ready=1. Accept → LOAD (op 0), STORE (1), EXEC (2–4), DONE with err latched (5–7).
- LOAD: lane counter k=0..LANES-1, one per cycle; mem_re=1, mem_addr=base+k. mem_rdata sampled each cycle after an issued read is written to lane k-1 of rd. After k=LANES-1 → LTAIL.
- LTAIL: mem_re=0; capture last lane (LANES-1); → DONE. Partially loaded rd lanes update as they arrive.
- STORE: k=0..LANES-1; mem_we=1, mem_addr=base+k, mem_wdata=lane k of rs1; → DONE.
- EXEC: one cycle; all lanes of rd ← f(rs1 lane, rs2 lane) simultaneously; ADD/SUB mod 2^EW, MUL keeps low EW bits of unsigned product. Operands read before write, so rd may equal rs1 and/or rs2. → DONE.
- DONE: done=1 for one cycle, err=1 if illegal; → IDLE. Illegal command modifies no register and issues no memory access.
- mem_re and mem_we never high together; both 0 outside LOAD/STORE.

## Timing
- Reset (async assert, sync-released use): state=IDLE, all registers=0, cmd_ready=1, busy=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Accept edge = E0. LOAD: reads in cycles 1..LANES, LTAIL cycle LANES+1, done in cycle LANES+2. STORE: writes in cycles 1..LANES, done in LANES+1. EXEC: compute cycle 1, done in cycle 2, rd visible on dbg_data from cycle 2. Illegal: done+err in cycle 1.
- cmd_ready returns high the cycle after done; back-to-back commands accepted with one idle cycle between.
- Reset asserted mid-command: abort immediately, strobes drop asynchronously, registers cleared, no done pulse.
- cmd_valid held while busy: not accepted, no side effect.

## Test plan
- Reset then dbg_sel=0..NREGS-1 → all dbg_data=0, cmd_ready=1, mem strobes 0.
- Memory preloaded word j=j+1; LOAD rd=1 addr=0x010 → mem_re high 16 cycles addresses 0x010..0x01F, done at E0+18, reg1 lane i = 0x11+i.
- LOAD addr=0x1FA (AW=9) → addresses 0x1FA..0x1FF,0x000..0x009, no err.
- reg1 lanes=0xFFFFFFFF, reg2 lanes=2: ADD rd=3 → lanes 0x00000001; SUB rd=3 rs1=2 rs2=1 → 0x00000003; MUL rd=1 rs1=1 rs2=2 (rd=rs1) → 0xFFFFFFFE.
- STORE rs1=3 addr=0x100 → 16 writes, mem_wdata=lane k, done at E0+17; op=6 → done+err at E0+1, no strobes, registers unchanged.
- Assert rst_n=0 at LOAD lane 5 → mem_re drops at once, reg cleared, no done; next command after release runs normally.
